// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: Avalon-MM peripheral that ramps the PWM duty register toward a target in fixed steps at a fixed interval.
// Optional interrupt output enabled by defining PWM_RAMP_IRQ_EN.
module pwm_ramp_sequencer #(
    parameter int          DUTY_W        = 16,
    parameter int          IVL_W         = 24,
    parameter logic [31:0] PWM_DUTY_ADDR = 32'h4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  s_address,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    output logic [31:0] m_address,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
`ifdef PWM_RAMP_IRQ_EN
    ,
    output logic        irq
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CALC, S_WRITE} state_t;

    state_t              state_q, state_d;
    logic                en_q, en_d;
    logic                done_q, done_d;
    logic [DUTY_W-1:0]   target_q, target_d;
    logic [DUTY_W-1:0]   step_q, step_d;
    logic [IVL_W-1:0]    ivl_q, ivl_d;
    logic [IVL_W-1:0]    cnt_q, cnt_d;
    logic [DUTY_W-1:0]   cur_q, cur_d;
    logic [DUTY_W-1:0]   next_q, next_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         ctrl_rd;
    logic [DUTY_W:0]     diff;
    logic [DUTY_W-1:0]   calc;
    logic [IVL_W-1:0]    reload;
    logic                up, start, go, instant, accept, finish, busy;
    logic                unused;

    assign unused  = ^s_writedata[31:IVL_W];
    assign start   = s_write && s_address == 3'd0 && s_writedata[1] && s_writedata[0];
    assign go      = start && state_q == S_IDLE && target_q != cur_q;
    assign instant = start && state_q == S_IDLE && target_q == cur_q;
    assign accept  = state_q == S_WRITE && !m_waitrequest;
    assign finish  = accept && next_q == target_q;
    assign reload  = ivl_q == '0 ? IVL_W'(1) : ivl_q;

    // The distance is formed one bit wider so the step comparison can never wrap;
    // a step is only applied when it stays strictly short of the target.
    assign up   = target_q > cur_q;
    assign diff = up ? {1'b0, target_q} - {1'b0, cur_q} : {1'b0, cur_q} - {1'b0, target_q};
    assign calc = (step_q == '0 || diff <= {1'b0, step_q}) ? target_q : (up ? cur_q + step_q : cur_q - step_q);

`ifdef PWM_RAMP_IRQ_EN
    logic msk_q;
    assign ctrl_rd = {29'd0, msk_q, 1'b0, en_q};
    // Interrupt mask bit and registered interrupt level
    always_ff @(posedge clk) begin
        if (reset) begin
            msk_q <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (s_write && s_address == 3'd0) msk_q <= s_writedata[2];
            irq <= done_q & msk_q;
        end
    end
`else
    assign ctrl_rd = {31'd0, en_q};
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    // FSM next state: clearing EN aborts while waiting, but a started bus write always completes
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = go ? S_WAIT : S_IDLE;
            S_WAIT:  state_d = !en_q ? S_IDLE : (cnt_q == IVL_W'(1) ? S_CALC : S_WAIT);
            S_CALC:  state_d = !en_q ? S_IDLE : S_WRITE;
            S_WRITE: state_d = !accept ? S_WRITE : ((finish || !en_q) ? S_IDLE : S_WAIT);
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: master request and status
    always_comb begin
        m_write     = state_q == S_WRITE;
        m_writedata = 32'(next_q);
        m_address   = PWM_DUTY_ADDR;
        busy        = state_q != S_IDLE;
        s_readdata  = rdata_q;
    end

    // Register file, interval counter and ramp datapath next state
    always_comb begin
        en_d     = en_q;
        target_d = target_q;
        step_d   = step_q;
        ivl_d    = ivl_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        next_d   = next_q;
        done_d   = done_q;
        rdata_d  = '0;
        if (s_write) begin
            case (s_address)
                3'd0:    en_d = s_writedata[0];
                3'd2:    target_d = s_writedata[DUTY_W-1:0];
                3'd3:    step_d = s_writedata[DUTY_W-1:0];
                3'd4:    ivl_d = s_writedata[IVL_W-1:0];
                default: en_d = en_q;
            endcase
        end
        if (s_write && s_address == 3'd1 && s_writedata[1]) done_d = 1'b0;
        if (instant || finish) done_d = 1'b1;
        if (go || (accept && !finish)) cnt_d = reload;
        else if (state_q == S_WAIT) cnt_d = cnt_q - IVL_W'(1);
        if (state_q == S_CALC && en_q) next_d = calc;
        if (accept) cur_d = next_q;
        if (s_read) begin
            case (s_address)
                3'd0:    rdata_d = ctrl_rd;
                3'd1:    rdata_d = {30'd0, done_q, busy};
                3'd2:    rdata_d = 32'(target_q);
                3'd3:    rdata_d = 32'(step_q);
                3'd4:    rdata_d = 32'(ivl_q);
                3'd5:    rdata_d = 32'(cur_q);
                default: rdata_d = '0;
            endcase
        end
    end

    // Register file and datapath state
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            target_q <= '0;
            step_q   <= '0;
            ivl_q    <= '0;
            cnt_q    <= '0;
            cur_q    <= '0;
            next_q   <= '0;
            rdata_q  <= '0;
        end else begin
            en_q     <= en_d;
            done_q   <= done_d;
            target_q <= target_d;
            step_q   <= step_d;
            ivl_q    <= ivl_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            next_q   <= next_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb_pwm_ramp_sequencer: self-checking bench for pwm_ramp_sequencer (register table, directed ramps, randomized ramps vs model).
module tb_pwm_ramp_sequencer;
    logic        clk = 1'b0, reset = 1'b1;
    logic [2:0]  s_address = '0;
    logic        s_write = 1'b0, s_read = 1'b0, m_waitrequest = 1'b0;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata, m_address, m_writedata;
    logic        m_write;
`ifdef PWM_RAMP_IRQ_EN
    logic        irq;
    localparam logic [31:0] CTRL_RB = 32'h5;
`else
    localparam logic [31:0] CTRL_RB = 32'h1;
`endif

    typedef struct {
        logic [2:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t    rv [11];
    int          checks = 0, errors = 0, cyc = 0, last_wr_cyc = 0;
    logic [31:0] acc_q [$];
    int          acc_cyc [$];
    int          exp_q [$];
    logic        stalled = 1'b0;
    logic [31:0] held = '0;

    pwm_ramp_sequencer dut (
        .clk(clk), .reset(reset),
        .s_address(s_address), .s_write(s_write), .s_writedata(s_writedata),
        .s_read(s_read), .s_readdata(s_readdata),
        .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest)
`ifdef PWM_RAMP_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: logs every accepted transfer and checks data stays put during a stall
    always @(negedge clk) begin
        if (!reset && m_write) begin
            if (stalled) begin
                checks++;
                if (m_writedata !== held) begin
                    errors++;
                    $display("FAIL stall_stable: m_writedata %h, held value %h", m_writedata, held);
                end
            end
            if (!m_waitrequest) begin
                acc_q.push_back(m_writedata);
                acc_cyc.push_back(cyc);
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = m_writedata;
            end
        end else stalled = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        s_address = a;
        s_writedata = d;
        s_write = 1'b1;
        last_wr_cyc = cyc;
        tick();
        s_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        s_address = a;
        s_read = 1'b1;
        tick();
        s_read = 1'b0;
        d = s_readdata;
    endtask

    task automatic wait_mwrite;
        int n = 0;
        while (!m_write && n < 300) begin
            tick();
            n++;
        end
        if (!m_write) fail("wait_m_write");
    endtask

    task automatic serve(input int stall);
        m_waitrequest = stall > 0;
        wait_mwrite();
        repeat (stall) tick();
        m_waitrequest = 1'b0;
        tick();
    endtask

    task automatic wait_idle;
        logic [31:0] st;
        int n = 0;
        rd(3'd1, st);
        while (st[0] && n < 500) begin
            rd(3'd1, st);
            n++;
        end
        if (st[0]) fail("wait_idle");
    endtask

    task automatic clear_log;
        acc_q.delete();
        acc_cyc.delete();
    endtask

    // Reference ramp: the sequence of duty values the PWM slave should receive
    task automatic model_ramp(input int cur, input int tgt, input int stp);
        exp_q.delete();
        while (cur != tgt) begin
            if (stp == 0 || (tgt > cur ? tgt - cur : cur - tgt) <= stp) cur = tgt;
            else cur = tgt > cur ? cur + stp : cur - stp;
            exp_q.push_back(cur);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int t0, n, cur_m, tgt, stp, ivl, diff;
        int up_exp [3] = '{4, 8, 10};
        int dn_exp [3] = '{7, 4, 1};
        int rt_exp [3] = '{4, 8, 6};
        rv[0]  = '{3'd2, 1'b1, 32'h1234_ABCD, 32'h0000_ABCD};
        rv[1]  = '{3'd3, 1'b1, 32'hFFFF_0007, 32'h0000_0007};
        rv[2]  = '{3'd4, 1'b1, 32'hFFFF_FFFF, 32'h00FF_FFFF};
        rv[3]  = '{3'd5, 1'b1, 32'h0000_1234, 32'h0000_0000};
        rv[4]  = '{3'd6, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
        rv[5]  = '{3'd7, 1'b0, 32'h0000_0000, 32'h0000_0000};
        rv[6]  = '{3'd1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
        rv[7]  = '{3'd0, 1'b1, 32'h0000_0005, CTRL_RB};
        rv[8]  = '{3'd0, 1'b1, 32'h0000_0000, 32'h0000_0000};
        rv[9]  = '{3'd2, 1'b1, 32'h0000_0000, 32'h0000_0000};
        rv[10] = '{3'd6, 1'b0, 32'h0000_0000, 32'h0000_0000};

        repeat (3) tick();
        chk("reset_readdata", s_readdata, 32'h0);
        chk("reset_m_write", {31'd0, m_write}, 32'h0);
        chk("reset_m_writedata", m_writedata, 32'h0);
        chk("m_address", m_address, 32'h4);
`ifdef PWM_RAMP_IRQ_EN
        chk("reset_irq", {31'd0, irq}, 32'h0);
`endif
        reset = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            if (rv[i].wr) wr(rv[i].addr, rv[i].wdata);
            rd(rv[i].addr, d);
            chk($sformatf("reg_vec%0d", i), d, rv[i].exp);
        end

        wr(3'd2, 32'd77);
        s_address = 3'd2;
        s_writedata = 32'd99;
        s_read = 1'b1;
        s_write = 1'b1;
        tick();
        s_read = 1'b0;
        s_write = 1'b0;
        chk("rw_same_cycle_old", s_readdata, 32'd77);
        rd(3'd2, d);
        chk("rw_same_cycle_new", d, 32'd99);

        // Basic ramp up 0 -> 10, step 4, interval 3
        wr(3'd2, 32'd10);
        wr(3'd3, 32'd4);
        wr(3'd4, 32'd3);
        clear_log();
        wr(3'd0, 32'h3);
        t0 = last_wr_cyc;
        wait_idle();
        chk("up_count", acc_q.size(), 3);
        for (int i = 0; i < 3 && i < acc_q.size(); i++) begin
            chk("up_value", acc_q[i], up_exp[i]);
            chk("up_cycle", acc_cyc[i], t0 + 5 * (i + 1));
        end
        rd(3'd1, d);
        chk("up_status", d, 32'h2);
        rd(3'd5, d);
        chk("up_current", d, 32'd10);

        // Ramp down 10 -> 1 with 5-cycle stalls; final accept coincides with DONE W1C
        wr(3'd1, 32'h2);
        wr(3'd2, 32'd1);
        wr(3'd3, 32'd3);
        wr(3'd4, 32'd2);
        clear_log();
        m_waitrequest = 1'b1;
        wr(3'd0, 32'h3);
        serve(5);
        serve(5);
        m_waitrequest = 1'b1;
        wait_mwrite();
        repeat (5) tick();
        m_waitrequest = 1'b0;
        s_address = 3'd1;
        s_writedata = 32'h2;
        s_write = 1'b1;
        tick();
        s_write = 1'b0;
        rd(3'd1, d);
        chk("done_set_wins", d, 32'h2);
        chk("dn_count", acc_q.size(), 3);
        for (int i = 0; i < 3 && i < acc_q.size(); i++) chk("dn_value", acc_q[i], dn_exp[i]);
        wr(3'd1, 32'h2);
        rd(3'd1, d);
        chk("done_w1c", d, 32'h0);

        // STEP=0, INTERVAL=0: one jump to 0xFFFF three cycles after START
        wr(3'd2, 32'hFFFF);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'd0);
        clear_log();
        wr(3'd0, 32'h3);
        t0 = last_wr_cyc;
        wait_idle();
        chk("edge_count", acc_q.size(), 1);
        if (acc_q.size() > 0) begin
            chk("edge_value", acc_q[0], 32'hFFFF);
            chk("edge_cycle", acc_cyc[0], t0 + 3);
        end

        // START with TARGET==CURRENT: DONE next cycle and no write
        wr(3'd1, 32'h2);
        clear_log();
        wr(3'd0, 32'h3);
        rd(3'd1, d);
        chk("instant_done", d, 32'h2);
        repeat (5) tick();
        chk("instant_no_write", acc_q.size(), 0);

        // Reset during a stalled transfer
        wr(3'd1, 32'h2);
        wr(3'd2, 32'd5);
        wr(3'd3, 32'd1);
        wr(3'd4, 32'd1);
        m_waitrequest = 1'b1;
        clear_log();
        wr(3'd0, 32'h3);
        wait_mwrite();
        tick();
        reset = 1'b1;
        s_address = 3'd2;
        s_read = 1'b1;
        tick();
        reset = 1'b0;
        s_read = 1'b0;
        m_waitrequest = 1'b0;
        chk("rst_m_write", {31'd0, m_write}, 32'h0);
        chk("rst_m_writedata", m_writedata, 32'h0);
        chk("rst_readdata", s_readdata, 32'h0);
        rd(3'd5, d);
        chk("rst_current", d, 32'h0);
        rd(3'd2, d);
        chk("rst_target", d, 32'h0);
        repeat (5) tick();
        chk("rst_no_write", acc_q.size(), 0);

        // Re-target 20 -> 6 once CURRENT reaches 8
        wr(3'd2, 32'd20);
        wr(3'd3, 32'd4);
        wr(3'd4, 32'd4);
        clear_log();
        wr(3'd0, 32'h3);
        n = 0;
        while (acc_q.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        if (acc_q.size() < 2) fail("retarget_wait");
        wr(3'd2, 32'd6);
        wait_idle();
        chk("rt_count", acc_q.size(), 3);
        for (int i = 0; i < 3 && i < acc_q.size(); i++) chk("rt_value", acc_q[i], rt_exp[i]);
        rd(3'd1, d);
        chk("rt_status", d, 32'h2);

        // EN cleared while waiting: abort, no writes, DONE stays 0
        wr(3'd1, 32'h2);
        wr(3'd2, 32'd40);
        wr(3'd3, 32'd5);
        wr(3'd4, 32'd10);
        clear_log();
        wr(3'd0, 32'h3);
        repeat (3) tick();
        wr(3'd0, 32'h0);
        tick();
        rd(3'd1, d);
        chk("abort_wait_status", d, 32'h0);
        repeat (15) tick();
        chk("abort_wait_no_write", acc_q.size(), 0);
        rd(3'd5, d);
        chk("abort_wait_current", d, 32'd6);

        // EN cleared during a stalled write: that write completes, then idle
        wr(3'd4, 32'd2);
        m_waitrequest = 1'b1;
        clear_log();
        wr(3'd0, 32'h3);
        wait_mwrite();
        tick();
        wr(3'd0, 32'h0);
        tick();
        m_waitrequest = 1'b0;
        repeat (20) tick();
        chk("abort_wr_count", acc_q.size(), 1);
        if (acc_q.size() > 0) chk("abort_wr_value", acc_q[0], 32'd11);
        rd(3'd1, d);
        chk("abort_wr_status", d, 32'h0);
        rd(3'd5, d);
        chk("abort_wr_current", d, 32'd11);

`ifdef PWM_RAMP_IRQ_EN
        wr(3'd2, 32'd11);
        wr(3'd0, 32'h7);
        tick();
        chk("irq_on", {31'd0, irq}, 32'h1);
        wr(3'd1, 32'h2);
        tick();
        chk("irq_cleared", {31'd0, irq}, 32'h0);
        wr(3'd0, 32'h3);
        repeat (2) tick();
        chk("irq_masked", {31'd0, irq}, 32'h0);
`endif

        // Randomized ramps against the reference model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cur_m = 0;
        for (int it = 0; it < 25; it++) begin
            tgt = ($urandom_range(0, 7) == 0) ? cur_m : int'($urandom_range(0, 65535));
            diff = tgt > cur_m ? tgt - cur_m : cur_m - tgt;
            stp = ($urandom_range(0, 4) == 0) ? 0 : diff / int'($urandom_range(1, 10)) + int'($urandom_range(0, 3));
            if (stp > 65535) stp = 65535;
            ivl = int'($urandom_range(0, 4));
            wr(3'd2, tgt);
            wr(3'd3, stp);
            wr(3'd4, ivl);
            wr(3'd1, 32'h2);
            model_ramp(cur_m, tgt, stp);
            clear_log();
            wr(3'd0, 32'h3);
            foreach (exp_q[i]) serve(int'($urandom_range(0, 3)));
            wait_idle();
            chk("rand_count", acc_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) chk("rand_value", acc_q[i], exp_q[i]);
            rd(3'd1, d);
            chk("rand_status", d, 32'h2);
            cur_m = tgt;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
